// File: rtl/keypad_scan_entry.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan_entry
// Description : Matrix-keypad row scanner with frame-based press/release
//               debounce and a multi-digit entry buffer (shift-in or direct
//               slot write).
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan_entry #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3,
  parameter int DIGITS   = 4,
  localparam int CW      = $clog2(ROWS * COLS),
  localparam int SW      = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [COLS-1:0]      swc,
  output logic [ROWS-1:0]      swr,
  input  logic                 entry_mode,
  input  logic [SW-1:0]        digit_sel,
  input  logic                 clear,
  output logic [CW-1:0]        key_code,
  output logic                 key_valid,
  output logic                 key_held,
  output logic [DIGITS*CW-1:0] digits
);

  localparam int         c_div_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int         c_row_w = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [3:0] c_deb   = 4'(DEBOUNCE);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  // Scan / frame state
  logic [c_div_w-1:0] div_q, div_d;
  logic [c_row_w-1:0] row_q, row_d;
  logic               acc_hit_q, acc_hit_d;
  logic [CW-1:0]      acc_code_q, acc_code_d;

  // Debounce state
  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [CW-1:0]      cand_q, cand_d;

  // Outputs and entry buffer
  logic [CW-1:0]      key_code_q, key_code_d;
  logic               key_valid_q, key_valid_d;
  logic [CW-1:0]      dig_q [DIGITS];
  logic [CW-1:0]      dig_d [DIGITS];

  // Combinational helpers
  logic               sample;
  logic               frame_end;
  logic               row_hit;
  logic [CW-1:0]      row_code;
  logic               frame_hit;
  logic [CW-1:0]      frame_code;
  logic               accept;

  // Row strobe, dwell divider and sample/frame-end qualifiers
  always_comb begin
    sample    = (div_q == c_div_w'(SCAN_DIV - 1));
    frame_end = sample && (row_q == c_row_w'(ROWS - 1));
    div_d     = sample ? '0 : div_q + 1'b1;
    row_d     = row_q;
    if (sample) begin
      row_d = (row_q == c_row_w'(ROWS - 1)) ? '0 : row_q + 1'b1;
    end
    swr = ~(ROWS'(1) << row_q);
  end

  // Lowest-index low column in the strobed row gives the row's code
  always_comb begin
    row_hit  = 1'b0;
    row_code = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!swc[c]) begin
        row_hit  = 1'b1;
        row_code = CW'(int'(row_q) * COLS + c);
      end
    end
  end

  // Frame accumulator: first hit row of the frame (lowest row) wins; row 0
  // starts a fresh frame so the previous frame's result is ignored there
  always_comb begin
    frame_hit  = row_hit;
    frame_code = row_code;
    if ((row_q != '0) && acc_hit_q) begin
      frame_hit  = 1'b1;
      frame_code = acc_code_q;
    end
    acc_hit_d  = acc_hit_q;
    acc_code_d = acc_code_q;
    if (sample) begin
      acc_hit_d  = frame_hit;
      acc_code_d = frame_code;
    end
  end

  // Debounce FSM next-state, evaluated only on frame end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (frame_hit) begin
            cand_d = frame_code;
            cnt_d  = 4'd1;
            if (DEBOUNCE == 1) begin
              accept  = 1'b1;
              state_d = HELD;
            end else begin
              state_d = PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if (!frame_hit) begin
            cnt_d   = 4'd0;
            state_d = IDLE;
          end else if (frame_code != cand_q) begin
            cand_d = frame_code;
            cnt_d  = 4'd1;
          end else begin
            cnt_d = cnt_q + 4'd1;
            if (4'(cnt_q + 4'd1) == c_deb) begin
              accept  = 1'b1;
              state_d = HELD;
            end
          end
        end
        HELD: begin
          // Other keys are ignored here: no rollover
          if (!frame_hit) begin
            cnt_d   = 4'd1;
            state_d = (DEBOUNCE == 1) ? IDLE : REL_DB;
          end
        end
        REL_DB: begin
          if (frame_hit) begin
            state_d = HELD;
          end else begin
            cnt_d = cnt_q + 4'd1;
            if (4'(cnt_q + 4'd1) == c_deb) begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Key event outputs and entry buffer update; clear beats accept for slots
  always_comb begin
    key_valid_d = accept;
    key_code_d  = accept ? cand_d : key_code_q;
    dig_d       = dig_q;
    if (clear) begin
      for (int k = 0; k < DIGITS; k++) begin
        dig_d[k] = '0;
      end
    end else if (accept) begin
      if (!entry_mode) begin
        dig_d[0] = cand_d;
        for (int k = 1; k < DIGITS; k++) begin
          dig_d[k] = dig_q[k-1];
        end
      end else begin
        // Out-of-range slot selects match no slot and write nothing
        for (int k = 0; k < DIGITS; k++) begin
          if (digit_sel == SW'(k)) begin
            dig_d[k] = cand_d;
          end
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      row_q       <= '0;
      acc_hit_q   <= 1'b0;
      acc_code_q  <= '0;
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      cand_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
        dig_q[k] <= '0;
      end
    end else begin
      div_q       <= div_d;
      row_q       <= row_d;
      acc_hit_q   <= acc_hit_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      dig_q       <= dig_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = (state_q == HELD) || (state_q == REL_DB);

  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_pack
      assign digits[k*CW +: CW] = dig_q[k];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scan_entry
// Description : Self-checking bench for keypad_scan_entry with a keypad
//               matrix model and an expected-event scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_entry;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  swc;
  logic [3:0]  swr;
  logic        entry_mode = 1'b0;
  logic [1:0]  digit_sel = 2'd0;
  logic        clear = 1'b0;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] digits;

  logic [15:0] keys = 16'h0;   // bit r*4+c = key (r,c) pressed

  typedef struct packed {
    logic [3:0]  code;
    logic [31:0] frame;
    logic [15:0] dig;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          frame_cnt = 0;
  logic [3:0]  prev_swr = 4'b1110;
  logic        kv_prev = 1'b0;
  logic [15:0] model = 16'h0;

  keypad_scan_entry dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .swc        (swc),
    .swr        (swr),
    .entry_mode (entry_mode),
    .digit_sel  (digit_sel),
    .clear      (clear),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_held   (key_held),
    .digits     (digits)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its column low while its row is strobed
  always_comb begin
    swc = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !swr[r]) swc[c] = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Frame counting and scoreboard compare on every key_valid pulse
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_swr = 4'b1110;
      kv_prev  = 1'b0;
    end else begin
      if (prev_swr == 4'b0111 && swr == 4'b1110) frame_cnt++;
      prev_swr = swr;
      if (key_valid) begin
        chk("valid_width", {31'b0, kv_prev}, 32'd0);
        if (sb.size() == 0) begin
          chk("sb_pending", sb.size(), 32'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("key_code", {28'b0, key_code}, {28'b0, e.code});
          chk("latency_frame", frame_cnt, e.frame);
          chk("digits_at_accept", {16'b0, digits}, {16'b0, e.dig});
        end
      end
      kv_prev = key_valid;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_frames(input int n);
    int tgt;
    int guard;
    tgt   = frame_cnt + n;
    guard = 0;
    while (frame_cnt < tgt && guard < n * 16 + 64) begin
      tick();
      guard++;
    end
    if (frame_cnt < tgt) chk("frame_timeout", frame_cnt, tgt);
  endtask

  // Queue the expected event for a press starting now, tracking the buffer
  task automatic expect_press(input logic [3:0] code);
    exp_t e;
    if (!entry_mode) begin
      model = {model[11:0], code};
    end else begin
      model[digit_sel*4 +: 4] = code;
    end
    e.code  = code;
    e.frame = frame_cnt + 3;
    e.dig   = model;
    sb.push_back(e);
  endtask

  task automatic press_release(input int r, input int c);
    expect_press(4'(r * 4 + c));
    keys = 16'h0;
    keys[r*4+c] = 1'b1;
    wait_frames(4);
    chk("held_after_accept", {31'b0, key_held}, 32'd1);
    keys = 16'h0;
    wait_frames(2);
    chk("held_during_release", {31'b0, key_held}, 32'd1);
    wait_frames(1);
    chk("released", {31'b0, key_held}, 32'd0);
    wait_frames(1);
  endtask

  initial begin
    logic [3:0] e_swr;
    // Reset and scan sequence
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      e_swr = ~(4'b0001 << (i / 4));
      chk("swr_scan", {28'b0, swr}, {28'b0, e_swr});
      if (i == 0) begin
        chk("reset_digits", {16'b0, digits}, 32'd0);
        chk("reset_valid", {31'b0, key_valid}, 32'd0);
        chk("reset_code", {28'b0, key_code}, 32'd0);
        chk("reset_held", {31'b0, key_held}, 32'd0);
      end
      @(negedge clk);
    end
    wait_frames(1);

    // Single presses
    press_release(3, 3);
    press_release(0, 0);
    press_release(2, 1);

    // Bounce on (1,2): 2 frames on, 1 off, never reaches debounce
    for (int k = 0; k < 3; k++) begin
      keys = 16'h0;
      keys[6] = 1'b1;
      wait_frames(2);
      keys = 16'h0;
      wait_frames(1);
    end
    chk("bounce_idle", {31'b0, key_held}, 32'd0);
    press_release(1, 2);

    // Shift entry
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model = 16'h0;
    chk("clear_digits", {16'b0, digits}, 32'd0);
    press_release(0, 1);
    press_release(0, 2);
    press_release(0, 3);
    press_release(1, 0);
    press_release(1, 1);
    chk("shift_digits", {16'b0, digits}, 32'h2345);

    // Direct entry into slot 2
    entry_mode = 1'b1;
    digit_sel  = 2'd2;
    press_release(1, 3);
    chk("direct_digits", {16'b0, digits}, 32'h2745);

    // Clear coinciding with accept: buffer cleared, event still reported
    model = 16'h0;
    begin
      exp_t e;
      e.code  = 4'd7;
      e.frame = frame_cnt + 3;
      e.dig   = 16'h0;
      sb.push_back(e);
    end
    keys = 16'h0;
    keys[7] = 1'b1;
    wait_frames(2);
    clear = 1'b1;
    wait_frames(1);
    clear = 1'b0;
    chk("clear_accept_digits", {16'b0, digits}, 32'd0);
    chk("clear_accept_code", {28'b0, key_code}, 32'd7);
    keys = 16'h0;
    wait_frames(4);
    entry_mode = 1'b0;

    // Second key added while held: no rollover
    expect_press(4'd1);
    keys = 16'h0;
    keys[1] = 1'b1;
    wait_frames(4);
    keys[12] = 1'b1;
    wait_frames(4);
    chk("no_rollover_code", {28'b0, key_code}, 32'd1);
    keys = 16'h0;
    wait_frames(4);

    // Two keys in one row: lowest column wins
    expect_press(4'd4);
    keys = 16'h0;
    keys[4] = 1'b1;
    keys[7] = 1'b1;
    wait_frames(4);
    keys = 16'h0;
    wait_frames(4);

    // Two keys in different rows: lowest row wins
    expect_press(4'd10);
    keys = 16'h0;
    keys[10] = 1'b1;
    keys[13] = 1'b1;
    wait_frames(4);
    keys = 16'h0;
    wait_frames(4);

    // Reset while held: outputs clear, key re-accepted after release
    expect_press(4'd9);
    keys = 16'h0;
    keys[9] = 1'b1;
    wait_frames(4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_held", {31'b0, key_held}, 32'd0);
    chk("rst_code", {28'b0, key_code}, 32'd0);
    chk("rst_digits", {16'b0, digits}, 32'd0);
    chk("rst_swr", {28'b0, swr}, 32'he);
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    model = 16'h0;
    expect_press(4'd9);
    wait_frames(4);
    chk("rst_reaccept_held", {31'b0, key_held}, 32'd1);
    keys = 16'h0;
    wait_frames(4);

    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keypad_scan_entry.md
# keypad_scan_entry

Parametrised matrix-keypad scanner with frame-based debounce and a multi-digit entry buffer. It drives active-low row strobes, samples active-low column returns, and emits one clean key event per physical press. Each accepted code is loaded into a DIGITS-deep register bank, either by shift-in or by direct slot write. It sits between the board keypad pins and the display/arith datapath, and generalises the fixed 4x4, two-register keypad front end.

## Interface
- ROWS, 4: keypad rows, 2..8
- COLS, 4: keypad columns, 2..8
- SCAN_DIV, 4: clocks per row dwell, ≥2
- DEBOUNCE, 3: consecutive identical frames required to accept a press or release, 1..15
- DIGITS, 4: entry buffer depth, ≥2
- CW (derived), clog2(ROWS*COLS): code width
- SW (derived), max(1, clog2(DIGITS)): slot-select width
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- swc  in  COLS  column returns, active low
- swr  out  ROWS  row strobes, exactly one bit low
- entry_mode  in  1  0 = shift-in, 1 = direct slot write
- digit_sel  in  SW  target slot in direct mode
- clear  in  1  synchronous clear of the entry buffer
- key_code  out  CW  last accepted code
- key_valid  out  1  one-cycle pulse per accepted press
- key_held  out  1  high while an accepted key remains pressed
- digits  out  DIGITS*CW  slot k at bits [k*CW +: CW]

## Operation
- Scan: row index r advances 0→ROWS-1→0. r changes after SCAN_DIV clocks. swr = ~(1<<r).
- Column sampling: swc is sampled only in the last dwell cycle of a row (divider = SCAN_DIV-1).
- Code: code = r*COLS + c, where c is the lowest-index low bit of swc. Several low columns in one row: lowest c wins. Several rows pressed in one frame: lowest r wins.
- Frame: ROWS*SCAN_DIV clocks. Ends at the sample of row ROWS-1. Frame result = (hit, code).
- FSM, evaluated only at frame end:
  - IDLE: on hit, set cand=code, cnt=1, go to PRESS_DB. If DEBOUNCE=1, accept immediately.
  - PRESS_DB: a hit with the same code increments cnt. A hit with a different code reloads cand and sets cnt=1. No hit returns to IDLE. When cnt reaches DEBOUNCE, accept and go to HELD.
  - HELD: no hit sets cnt=1 and goes to REL_DB. Any hit, including a different key, is ignored (no rollover).
  - REL_DB: consecutive no-hit frames increment cnt. Any hit returns to HELD. When cnt reaches DEBOUNCE, go to IDLE.
- Accept: key_code ← cand and key_valid = 1 for exactly one cycle. key_held = 1 in HELD and REL_DB.
- Buffer update, on the accept edge:
  - Shift mode: slot0 ← code, slot k ← slot k-1, and the old slot DIGITS-1 is discarded.
  - Direct mode: slot[digit_sel] ← code. digit_sel ≥ DIGITS means no write, but key_valid still pulses.
- clear: zeroes all slots. When clear and accept fall on the same edge, clear wins for the buffer; key_code and key_valid still update.
- entry_mode and digit_sel are sampled on the accept edge only.

## Timing
- Reset values: swr = ~1 (row 0 low), divider 0, FSM IDLE, cnt 0, key_code 0, key_valid 0, key_held 0, all digits 0.
- Reset asserted mid-press or mid-debounce: outputs go to the reset values immediately. After release, the FSM restarts in IDLE, so a key still held is re-accepted after DEBOUNCE frames.
- Accept latency: key_valid, key_code and digits update on the frame-end edge that completes debounce. That is DEBOUNCE frame ends after the first hit frame end, counting that first one.
- A single press yields exactly one key_valid regardless of hold time.
- Glitches shorter than DEBOUNCE frames produce no event. Release glitches shorter than DEBOUNCE frames do not end HELD.

## Test plan
Common setup: defaults, so one frame = 16 clocks. The keypad model pulls swc[c] low while swr[r] is low.
- Reset: after rst_n rises, swr sequence 1110,1101,1011,0111 with 4 clocks each; digits = 0 and key_valid = 0.
- Single press:
  - Hold (3,3): after exactly 3 frame ends, key_valid pulses once, key_code = 15, key_held = 1.
  - Release: after 3 clean frames, key_held = 0.
  - Hold (0,0): key_code = 0. Hold (2,1): key_code = 9.
- Bounce:
  - (1,2) present for 2 frames, then absent for 1 frame, repeated: no key_valid.
  - Then held steadily: one pulse with key_code = 6.
- Shift entry: entry_mode = 0, press 1,2,3,4,5 in turn → digits slots {3..0} = {2,3,4,5}.
- Direct entry:
  - entry_mode = 1, digit_sel = 2, press 7 → only slot 2 = 7.
  - Same press with clear high on the accept edge → all slots 0, key_code = 7.
- Two keys:
  - Hold (0,1), then add (3,0) → no second pulse.
  - Hold (1,0) and (1,3) together → key_code = 4.
  - rst_n pulsed during HELD with the key still held → exactly one new pulse 3 frames after reset release.
